// File: rtl/path_streamer.sv
// Path output engine: buffers a coordinate path and streams it as packed {x,y} words over valid/ready.
// Optional macro PATH_STREAMER_REVERSE_EN adds a `reverse` input for descending-order streaming.
module path_streamer #(
    parameter int unsigned COORD_W = 16,
    parameter int unsigned MAX_LEN = 100,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [LEN_W-1:0]     wr_addr,
    input  logic [2*COORD_W-1:0] wr_data,
    input  logic                 start,
    input  logic [LEN_W-1:0]     length,
`ifdef PATH_STREAMER_REVERSE_EN
    input  logic                 reverse,
`endif
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*COORD_W-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned DW = 2 * COORD_W;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FINISH} state_t;

    state_t           state, state_d;
    logic [LEN_W-1:0] index, index_d;
    logic [LEN_W-1:0] len, len_d;
    logic             rev, rev_d, rev_in;
    logic             valid_d, last_d, busy_d, done_d, error_d;
    logic [DW-1:0]    data_d;
    logic             len_ok, at_end;

    logic [DW-1:0]    mem [MAX_LEN];

`ifdef PATH_STREAMER_REVERSE_EN
    assign rev_in = reverse;
`else
    assign rev_in = 1'b0;
`endif

    assign len_ok = (length != '0) && (length <= LEN_W'(MAX_LEN));
    assign at_end = rev ? (index == '0) : (index == len - LEN_W'(1));

    // Path buffer: writable only while idle, out-of-range addresses dropped
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en && wr_addr < LEN_W'(MAX_LEN)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            index     <= '0;
            len       <= '0;
            rev       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_d;
            index     <= index_d;
            len       <= len_d;
            rev       <= rev_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_last  <= last_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

    // Next state and next registered outputs; done is raised on leaving FINISH so abort can suppress it
    always_comb begin
        state_d = state;
        index_d = index;
        len_d   = len;
        rev_d   = rev;
        valid_d = out_valid;
        data_d  = out_data;
        last_d  = out_last;
        done_d  = 1'b0;
        error_d = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d   = length;
                        rev_d   = rev_in;
                        index_d = rev_in ? length - LEN_W'(1) : '0;
                        state_d = FETCH;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                data_d  = mem[index];
                valid_d = 1'b1;
                last_d  = at_end;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (out_last) begin
                        state_d = FINISH;
                    end else begin
                        index_d = rev ? index - LEN_W'(1) : index + LEN_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort && state != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
            error_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_path_streamer.sv
// Randomized self-checking bench for path_streamer against a shadow-buffer/queue model.
module tb_path_streamer;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned MAX_LEN = 100;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned DW      = 2 * COORD_W;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             wr_en;
    logic [LEN_W-1:0] wr_addr;
    logic [DW-1:0]    wr_data;
    logic             start;
    logic [LEN_W-1:0] length;
`ifdef PATH_STREAMER_REVERSE_EN
    logic             reverse;
`endif
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             error;

    logic [DW-1:0]    shadow [MAX_LEN];
    int               n_tests = 0;
    int               n_fail  = 0;

    path_streamer #(.COORD_W(COORD_W), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .length    (length),
`ifdef PATH_STREAMER_REVERSE_EN
        .reverse   (reverse),
`endif
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic write_word(input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = LEN_W'(addr);
        wr_data = data;
        if (addr < int'(MAX_LEN)) shadow[addr] = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic reject(input int n);
        start  = 1'b1;
        length = LEN_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check("reject_err", error, 1);
        check("reject_busy", busy, 0);
        check("reject_valid", out_valid, 0);
        @(posedge clk); #1;
        check("reject_err_pulse", error, 0);
        check("reject_valid2", out_valid, 0);
    endtask

    // Stream n words and compare against the shadow buffer in the requested order
    task automatic run_stream(input int n, input bit rv, input int stall_pct, input int hold_k,
                              input int abort_at, input bit abort_last);
        logic [DW-1:0] exp_q [$];
        int got, cyc, held;
        bit hs, was_hs;
        got = 0; cyc = 0; held = 0; was_hs = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(shadow[rv ? n - 1 - i : i]);
        start  = 1'b1;
        length = LEN_W'(n);
`ifdef PATH_STREAMER_REVERSE_EN
        reverse = rv;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        check("busy_start", busy, 1);
        check("valid_fetch", out_valid, 0);
        @(posedge clk); #1;
        check("first_valid", out_valid, 1);
        forever begin
            if (was_hs) check("valid_drop", out_valid, 0);
            out_ready = 1'b0;
            hs = 1'b0;
            if (out_valid) begin
                check("data", out_data, exp_q[got]);
                check("last", out_last, (got == n - 1));
                if (got == hold_k && held < 5) held++;
                else out_ready = ($urandom_range(99) >= stall_pct);
                hs = out_ready;
            end else begin
                out_ready = 1'($urandom_range(1));
            end
            if (hs) got++;
            abort = 1'b0;
            if (abort_last && hs && got == n) abort = 1'b1;
            if (abort_at > 0 && was_hs && !hs && got == abort_at) begin
                abort   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = 32'hDEAD_BEEF;
            end
            was_hs = hs;
            cyc++;
            @(posedge clk); #1;
            wr_en = 1'b0;
            if (abort) begin
                abort     = 1'b0;
                out_ready = 1'b0;
                check("abort_valid", out_valid, 0);
                check("abort_err", error, 1);
                check("abort_busy", busy, 0);
                check("abort_no_done", done, 0);
                @(posedge clk); #1;
                check("abort_done_after", done, 0);
                check("abort_err_pulse", error, 0);
                return;
            end
            if (got == n) break;
            if (cyc > 2000) begin
                check("timeout_words", 64'(got), 64'(n));
                return;
            end
        end
        out_ready = 1'b0;
        check("fin_valid", out_valid, 0);
        check("fin_done", done, 0);
        check("fin_busy", busy, 1);
        @(posedge clk); #1;
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        @(posedge clk); #1;
        check("done_once", done, 0);
    endtask

    initial begin
        bit rv;
        int n;
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; length = '0; abort = 1'b0; out_ready = 1'b0;
`ifdef PATH_STREAMER_REVERSE_EN
        reverse = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        write_word(0, 32'h0001_0002);
        write_word(1, 32'h0003_0004);
        write_word(2, 32'h0005_0006);
        write_word(int'(MAX_LEN), 32'hFFFF_FFFF);
        run_stream(3, 1'b0, 0, -1, 0, 1'b0);
        run_stream(3, 1'b0, 0, 1, 0, 1'b0);

        reject(0);
        reject(int'(MAX_LEN) + 1);

`ifdef PATH_STREAMER_REVERSE_EN
        run_stream(3, 1'b1, 0, -1, 0, 1'b0);
`endif

        for (int i = 0; i < int'(MAX_LEN); i++) write_word(i, DW'(i));
        run_stream(int'(MAX_LEN), 1'b0, 20, -1, 0, 1'b0);

        for (int i = 0; i < 5; i++) write_word(i, DW'($urandom));
        run_stream(5, 1'b0, 0, -1, 2, 1'b0);
        run_stream(1, 1'b0, 0, -1, 0, 1'b0);
        run_stream(3, 1'b0, 30, -1, 0, 1'b1);

        // write and start in the same cycle
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 32'h0ABC_0DEF;
        shadow[0] = 32'h0ABC_0DEF;
        run_stream(1, 1'b0, 0, -1, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) write_word(i, DW'($urandom));
            rv = 1'b0;
`ifdef PATH_STREAMER_REVERSE_EN
            rv = 1'($urandom_range(1));
`endif
            run_stream(n, rv, int'($urandom_range(0, 60)), -1, 0, 1'b0);
        end

        // asynchronous reset while a word is presented
        write_word(0, 32'h1234_5678);
        start = 1'b1; length = LEN_W'(1);
`ifdef PATH_STREAMER_REVERSE_EN
        reverse = 1'b0;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_last", out_last, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_last", out_last, 0);
        check("async_data", out_data, 0);
        check("async_busy", busy, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_stream(1, 1'b0, 0, -1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
